// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants: PC increment and the default reset PC.
package riscv_pkg;

  localparam int          PC_STEP          = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction-queue storage for fetch_queue: flushable FIFO with a visible
// occupancy count. Pointers wrap naturally because DEPTH is a power of two.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_pushData,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_popData,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W:0]   r_count;

  // Storage needs no reset; only entries below the count are ever read.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wrPtr] <= i_pushData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (i_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_popData = r_mem[r_rdPtr];
  assign o_count   = r_count;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch unit: credit-limited requests into a small instruction queue with redirect flush.
// Optional macro FETCH_QUEUE_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int                       WORD_BITWIDTH = 32,
  parameter int                       DEPTH         = 4,
  parameter logic [WORD_BITWIDTH-1:0] RESET_PC      = WORD_BITWIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     inst_ce_o,
  output logic [WORD_BITWIDTH-1:0] inst_addr_o,
  input  logic [WORD_BITWIDTH-1:0] inst_i,
  input  logic                     redirect_i,
  input  logic [WORD_BITWIDTH-1:0] redirect_pc_i,
  output logic                     valid_o,
  output logic [WORD_BITWIDTH-1:0] pc_o,
  output logic [WORD_BITWIDTH-1:0] inst_o,
  input  logic                     ready_i
);

  localparam int W     = WORD_BITWIDTH;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [W-1:0]     r_fetchPc;
  logic [W-1:0]     r_inflightPc;
  logic             r_inflight;
  logic             r_kill;

  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_occupancy;
  logic [2*W-1:0]   w_headData;
  logic             w_headValid;
  logic             w_respLive;
  logic             w_push;
  logic             w_fifoPop;
  logic             w_issue;

  assign w_headValid = (w_count != '0);
  assign w_respLive  = r_inflight & ~r_kill & ~redirect_i & ~rst;
  assign w_fifoPop   = w_headValid & ready_i & ~redirect_i & ~rst;

  // Queued entries plus the one response in flight must never exceed the queue size.
  assign w_occupancy = w_count - CNT_W'(w_fifoPop) + CNT_W'(r_inflight);
  assign w_issue     = ~rst & ~redirect_i & (w_occupancy < CNT_W'(DEPTH));

  assign inst_ce_o   = w_issue;
  assign inst_addr_o = r_fetchPc;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic w_bypass;

  // An empty queue lets the arriving response go straight to decode.
  assign w_bypass = w_respLive & ~w_headValid;
  assign valid_o  = ~rst & (w_headValid | w_bypass);
  assign pc_o     = w_bypass ? r_inflightPc : w_headData[2*W-1:W];
  assign inst_o   = w_bypass ? inst_i       : w_headData[W-1:0];
  assign w_push   = w_respLive & ~(w_bypass & ready_i);
`else
  assign valid_o  = ~rst & w_headValid;
  assign pc_o     = w_headData[2*W-1:W];
  assign inst_o   = w_headData[W-1:0];
  assign w_push   = w_respLive;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetchPc    <= RESET_PC;
      r_inflightPc <= RESET_PC;
      r_inflight   <= 1'b0;
      r_kill       <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_kill     <= redirect_i & r_inflight;
      if (redirect_i) begin
        r_fetchPc <= redirect_pc_i;
      end else if (w_issue) begin
        r_fetchPc <= r_fetchPc + W'(PC_STEP);
      end
      if (w_issue) begin
        r_inflightPc <= r_fetchPc;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (2*W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (redirect_i),
    .i_push     (w_push),
    .i_pushData ({r_inflightPc, inst_i}),
    .i_pop      (w_fifoPop),
    .o_popData  (w_headData),
    .o_count    (w_count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model checked every cycle,
// plus directed literal checks for latency, credit limit, redirect, reset and PC wrap.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  // Main DUT (RESET_PC = 0) signals
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        readyI = 1'b1;
  logic        redirectI = 1'b0;
  logic [31:0] redirectPcI = 32'h0;
  logic [31:0] instI = 32'h0;
  logic        instCe;
  logic [31:0] instAddr;
  logic        validO;
  logic [31:0] pcO;
  logic [31:0] instO;

  // Second DUT with a wrapping RESET_PC
  logic        d2Ready = 1'b1;
  logic        d2Redirect = 1'b0;
  logic [31:0] d2RedirectPc = 32'h0;
  logic [31:0] d2Inst = 32'h0;
  logic        d2Ce;
  logic [31:0] d2Addr;
  logic        d2Valid;
  logic [31:0] d2Pc;
  logic [31:0] d2InstO;
  logic        d2Pend = 1'b0;
  logic [31:0] d2PendAddr = 32'h0;
  logic        d2Done = 1'b0;

  int          testsRun = 0;
  int          testsFailed = 0;
  logic [31:0] dataKey = 32'h0;
  logic        pendReq = 1'b0;
  logic [31:0] pendAddr = 32'h0;

  // Reference model state
  entry_t      q[$];
  logic [31:0] mPc = 32'h0;
  logic        mInfl = 1'b0;
  logic [31:0] mInflAddr = 32'h0;

  fetch_queue #(
    .WORD_BITWIDTH (32),
    .DEPTH         (DEPTH),
    .RESET_PC      (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .inst_ce_o     (instCe),
    .inst_addr_o   (instAddr),
    .inst_i        (instI),
    .redirect_i    (redirectI),
    .redirect_pc_i (redirectPcI),
    .valid_o       (validO),
    .pc_o          (pcO),
    .inst_o        (instO),
    .ready_i       (readyI)
  );

  fetch_queue #(
    .WORD_BITWIDTH (32),
    .DEPTH         (DEPTH),
    .RESET_PC      (32'hFFFF_FFF8)
  ) dut2 (
    .clk           (clk),
    .rst           (rst),
    .inst_ce_o     (d2Ce),
    .inst_addr_o   (d2Addr),
    .inst_i        (d2Inst),
    .redirect_i    (d2Redirect),
    .redirect_pc_i (d2RedirectPc),
    .valid_o       (d2Valid),
    .pc_o          (d2Pc),
    .inst_o        (d2InstO),
    .ready_i       (d2Ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memData(input logic [31:0] addr);
    return addr ^ dataKey;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic rd, input logic rdir, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rst         = r;
    readyI      = rd;
    redirectI   = rdir;
    redirectPcI = rpc;
  endtask

  // Memories: capture the request mid-cycle, answer one cycle later.
  always @(negedge clk) begin
    pendReq    = instCe;
    pendAddr   = instAddr;
    d2Pend     = d2Ce;
    d2PendAddr = d2Addr;
  end

  always @(posedge clk) begin
    #1;
    instI  = pendReq ? memData(pendAddr) : 32'hDEAD_BEEF;
    d2Inst = d2Pend ? d2PendAddr : 32'hDEAD_BEEF;
  end

  // Cycle model: an expected-entry queue, a fetch PC and one in-flight slot.
  always @(negedge clk) begin
    int          qs;
    int          occ;
    bit          mValid;
    bit          mPop;
    bit          mCe;
    bit          mBypass;
    logic [31:0] mHeadPc;
    logic [31:0] mHeadInst;
    if (rst) begin
      checkOutput("rst_ce", {31'b0, instCe}, 32'h0);
      checkOutput("rst_valid", {31'b0, validO}, 32'h0);
      q.delete();
      mPc   = 32'h0;
      mInfl = 1'b0;
    end else begin
      qs        = q.size();
      mBypass   = 1'b0;
      mHeadPc   = 32'h0;
      mHeadInst = 32'h0;
      mValid    = (qs != 0);
      if (mValid) begin
        mHeadPc   = q[0].pc;
        mHeadInst = q[0].inst;
      end
`ifdef FETCH_QUEUE_BYPASS_EN
      if (!mValid && mInfl && !redirectI) begin
        mBypass   = 1'b1;
        mValid    = 1'b1;
        mHeadPc   = mInflAddr;
        mHeadInst = memData(mInflAddr);
      end
`endif
      mPop = mValid && readyI && !redirectI;
      occ  = qs - ((mPop && !mBypass) ? 1 : 0) + (mInfl ? 1 : 0);
      mCe  = !redirectI && (occ < DEPTH);

      checkOutput("model_ce", {31'b0, instCe}, {31'b0, mCe});
      if (mCe) checkOutput("model_addr", instAddr, mPc);
      checkOutput("model_valid", {31'b0, validO}, {31'b0, mValid});
      if (mValid) begin
        checkOutput("model_pc", pcO, mHeadPc);
        checkOutput("model_inst", instO, mHeadInst);
      end

      if (redirectI) begin
        q.delete();
        mPc   = redirectPcI;
        mInfl = 1'b0;
      end else begin
        if (mPop && !mBypass) void'(q.pop_front());
        if (mInfl && !(mBypass && mPop)) q.push_back('{mInflAddr, memData(mInflAddr)});
        if (mCe) begin
          mInfl     = 1'b1;
          mInflAddr = mPc;
          mPc       = mPc + 32'd4;
        end else begin
          mInfl = 1'b0;
        end
      end
    end
  end

  // Wrapping RESET_PC instance: first four pops after the first reset release.
  initial begin
    int          idx;
    logic [31:0] exp2 [4];
    exp2 = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    idx  = 0;
    for (int i = 0; i < 50 && rst; i++) @(negedge clk);
    for (int i = 0; i < 12 && idx < 4; i++) begin
      @(negedge clk);
      if (!rst && d2Valid) begin
        checkOutput("wrap_pc", d2Pc, exp2[idx]);
        checkOutput("wrap_inst", d2InstO, exp2[idx]);
        idx++;
      end
    end
    if (idx < 4) checkOutput("wrap_pops", idx, 4);
    d2Done = 1'b1;
  end

  initial begin
    int          reqCount;
    logic [15:0] readyPat;
    readyPat = 16'b1011_0010_1110_0101;

    // Reset, then stream with ready held: latency and back-to-back addresses
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("c0_ce", {31'b0, instCe}, 32'h1);
    checkOutput("c0_addr", instAddr, 32'h0);
    @(negedge clk);
    checkOutput("c1_valid", {31'b0, validO}, 32'h0);
    checkOutput("c1_addr", instAddr, 32'h4);
    @(negedge clk);
    checkOutput("c2_valid", {31'b0, validO}, 32'h1);
    checkOutput("c2_pc", pcO, 32'h0);
    checkOutput("c2_addr", instAddr, 32'h8);
    @(negedge clk);
    checkOutput("c3_pc", pcO, 32'h4);
    checkOutput("c3_inst", instO, 32'h4);
    repeat (4) @(negedge clk);

    // Decode stalled from reset: exactly four requests then the queue is full
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    reqCount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (instCe) reqCount++;
    end
    checkOutput("stall_reqs", reqCount, 4);
    checkOutput("stall_ce", {31'b0, instCe}, 32'h0);
    checkOutput("stall_pc", pcO, 32'h0);

    // One-cycle ready pulse on a full queue buys exactly one request
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("pulse_ce", {31'b0, instCe}, 32'h1);
    checkOutput("pulse_addr", instAddr, 32'h10);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("pulse_next_ce", {31'b0, instCe}, 32'h0);
    checkOutput("pulse_head", pcO, 32'h4);
    repeat (2) @(negedge clk);
    checkOutput("refill_ce", {31'b0, instCe}, 32'h0);

    // Reset with three entries queued and one in flight
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("pre_rst_addr", instAddr, 32'h14);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("midrst_valid", {31'b0, validO}, 32'h0);
    checkOutput("midrst_ce", {31'b0, instCe}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    dataKey = 32'h1234_0000;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("restart_ce", {31'b0, instCe}, 32'h1);
    checkOutput("restart_addr", instAddr, 32'h0);
    checkOutput("restart_valid", {31'b0, validO}, 32'h0);

    // Redirect while the response for 0x8 is in flight
    repeat (2) @(negedge clk);
    checkOutput("key_inst", instO, 32'h1234_0000);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h100);
    @(negedge clk);
    checkOutput("redir_ce", {31'b0, instCe}, 32'h0);
    checkOutput("redir_head", pcO, 32'h4);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("redir_valid", {31'b0, validO}, 32'h0);
    checkOutput("redir_addr", instAddr, 32'h100);
    @(negedge clk);
    checkOutput("redir_valid2", {31'b0, validO}, 32'h0);
    @(negedge clk);
    checkOutput("redir_pc", pcO, 32'h100);
    checkOutput("redir_inst", instO, 32'h1234_0100);

    // Redirect near the top of the address space to exercise PC wrap
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("wrapr_addr", instAddr, 32'hFFFF_FFF8);
    repeat (2) @(negedge clk);
    checkOutput("wrapr_pc0", pcO, 32'hFFFF_FFF8);
    @(negedge clk);
    checkOutput("wrapr_pc1", pcO, 32'hFFFF_FFFC);
    @(negedge clk);
    checkOutput("wrapr_pc2", pcO, 32'h0);
    @(negedge clk);
    checkOutput("wrapr_pc3", pcO, 32'h4);

    // Irregular ready pattern with a redirect in the middle; the model checks every cycle
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, readyPat[i], (i == 9), 32'h200);
    end
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);

    for (int i = 0; i < 200 && !d2Done; i++) @(negedge clk);
    if (!d2Done) checkOutput("wrap_timeout", {31'b0, d2Done}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter WORD_BITWIDTH, default 32: width of the PC, the instruction and the memory address.
REQ-002 SHALL have parameter DEPTH, default 4: number of instruction-queue entries; power of two, at least 2.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000: PC fetched first after reset.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 inst_ce_o  output  1  instruction-memory request strobe.
REQ-008 inst_addr_o  output  WORD_BITWIDTH  request address, meaningful while inst_ce_o=1.
REQ-009 inst_i  input  WORD_BITWIDTH  memory data, valid exactly 1 cycle after each inst_ce_o=1.
REQ-010 redirect_i  input  1  flush and restart fetch (branch taken / jump).
REQ-011 redirect_pc_i  input  WORD_BITWIDTH  target PC, sampled while redirect_i=1.
REQ-012 valid_o  output  1  head entry available to decode.
REQ-013 pc_o  output  WORD_BITWIDTH  PC of the head entry.
REQ-014 inst_o  output  WORD_BITWIDTH  instruction of the head entry.
REQ-015 ready_i  input  1  decode accepts the head entry; pop when valid_o&ready_i.

Function
REQ-016 SHALL keep fetch_pc; inst_addr_o=fetch_pc combinationally; fetch_pc advances by 4 (modulo 2^WORD_BITWIDTH, FFFFFFFC wraps to 0) on each issued request.
REQ-017 SHALL drive inst_ce_o=1 only when count + inflight (after this cycle's pop) < DEPTH and redirect_i=0; inflight is a 1-bit register = inst_ce_o of the previous cycle.
REQ-018 SHALL enqueue {fetch address, inst_i} one cycle after a request unless the response is killed; the queue therefore never overflows.
REQ-019 SHALL present the oldest entry on valid_o/pc_o/inst_o; valid_o=(count!=0); pc_o/inst_o are don't-care when valid_o=0.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; full (count=DEPTH) and empty (count=0) SHALL each wrap read/write pointers modulo DEPTH.
REQ-021 redirect_i=1 SHALL in the same edge: clear count and pointers, set fetch_pc=redirect_pc_i, mark any inflight response killed (discarded next cycle), ignore ready_i; inst_ce_o=0 in the redirect cycle, and the first request to redirect_pc_i is issued the following cycle.
REQ-022 Latency (macro off): request at cycle N -> valid_o=1 at cycle N+2; sustained throughput 1 instruction/cycle with ready_i held 1.
REQ-023 SHALL hold pc_o/inst_o stable while valid_o=1 and ready_i=0.

Reset
REQ-024 While rst=1: fetch_pc=RESET_PC, count=0, pointers=0, inflight=0, kill=0, valid_o=0, inst_ce_o=0.
REQ-025 First cycle with rst=0: inst_ce_o=1, inst_addr_o=RESET_PC; reset mid-operation SHALL discard all entries and inflight data.

Configuration
REQ-026 Macro FETCH_QUEUE_BYPASS_EN defined: when count=0 and a non-killed response arrives, valid_o=1 with pc/inst taken directly from the response that cycle; if ready_i=1 it is consumed and not enqueued; latency N+1.
REQ-027 Macro undefined: every response goes through the queue; latency per REQ-022; no combinational path inst_i->inst_o.

Structure
REQ-028 PC_STEP (4) and RESET_PC default SHALL live in shared package riscv_pkg.
REQ-029 Queue storage/pointers SHALL be sub-module fetch_fifo (parameters WIDTH=2*WORD_BITWIDTH, DEPTH); PC, credit, kill and bypass logic in fetch_queue.

Verification
REQ-030 Reset release, ready_i=1, mem returns addr as data -> addresses 0,4,8,... on consecutive cycles; valid_o first at cycle 2 (cycle 1 with macro); pc_o=inst_o each pop.
REQ-031 ready_i=0 from reset, DEPTH=4 -> exactly 4 requests (0..C) issued, then inst_ce_o=0; head stays pc_o=0.
REQ-032 Queue full, ready_i pulsed 1 cycle -> exactly one new request at 0x10, count returns to 4.
REQ-033 redirect_i=1, redirect_pc_i=0x100 with inflight request at 0x8 -> 0x8 never appears; valid_o=0 next cycle; next pc_o=0x100.
REQ-034 RESET_PC=32'hFFFFFFF8, ready_i=1 -> pc_o sequence FFFFFFF8, FFFFFFFC, 0, 4.
REQ-035 rst asserted with count=3 -> next cycle valid_o=0, inst_ce_o=0; after release fetch restarts at RESET_PC.
